xbar_rob_channel: RTL and testbench

Per-channel reorder buffer at the cross-bar output, one instance per requesting channel (CHANNEL_ID). The requester allocates in-order ROB tags. Any of NUM_BANKS cache banks may return tagged data out of order. The block writes each response into its tagged slot and releases data strictly in allocation order through a valid/ready port. It generalises the fixed 4-bank, 8-entry, 128-bit write-only buffer with configurable banks, depth and width, tag allocation, in-order drain and error detection.

---
 rtl/xbar_rob_channel.sv | 178 +++++++++++++++++
 tb/tb_xbar_rob_channel.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_rob_channel.sv
// xbar_rob_channel
//   Per-channel reorder buffer sitting at the cross-bar output. The requester
//   allocates tags in order. Banks return tagged data in any order, and the
//   buffer releases that data strictly in allocation order.
//
// Ports
//   clk_i, rst_i      clock; asynchronous active-low reset
//   bank_valid_i      per-bank response valid
//   bank_allowIn_o    per-bank accept; combinational, 0 for other channels
//   bank_ch_id_i      per-bank channel id, bank b at [b*CH_ID_W +: CH_ID_W]
//   bank_rob_num_i    per-bank slot tag, bank b at [b*ROB_W +: ROB_W]
//   bank_data_i       per-bank data, bank b at [b*DATA_W +: DATA_W]
//   alloc_valid_i     requester asks for a tag
//   alloc_ready_o     a slot is free (registered count only)
//   alloc_rob_num_o   tag granted on the alloc handshake (tail pointer)
//   out_valid_o       head slot holds its response
//   out_ready_i       consumer accepts the head
//   out_rob_num_o     head tag
//   out_data_o        head slot data
//   count_o           number of allocated slots, 0..ROB_DEPTH
//   err_o             sticky protocol error; cleared only by reset
module xbar_rob_channel #(
  parameter int CHANNEL_ID = 0,
  parameter int NUM_BANKS  = 4,
  parameter int ROB_DEPTH  = 8,
  parameter int ROB_W      = $clog2(ROB_DEPTH),
  parameter int DATA_W     = 128,
  parameter int CH_ID_W    = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_BANKS-1:0]           bank_valid_i,
  output logic [NUM_BANKS-1:0]           bank_allowIn_o,
  input  logic [NUM_BANKS*CH_ID_W-1:0]   bank_ch_id_i,
  input  logic [NUM_BANKS*ROB_W-1:0]     bank_rob_num_i,
  input  logic [NUM_BANKS*DATA_W-1:0]    bank_data_i,
  input  logic                           alloc_valid_i,
  output logic                           alloc_ready_o,
  output logic [ROB_W-1:0]               alloc_rob_num_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [ROB_W-1:0]               out_rob_num_o,
  output logic [DATA_W-1:0]              out_data_o,
  output logic [ROB_W:0]                 count_o,
  output logic                           err_o
);

  typedef enum logic [1:0] {
    SLOT_FREE  = 2'd0,
    SLOT_ALLOC = 2'd1,
    SLOT_DONE  = 2'd2
  } slot_state_e;

  localparam logic [ROB_W:0]     DEPTH_C = (ROB_W + 1)'(ROB_DEPTH);
  localparam logic [CH_ID_W-1:0] CH_C    = CH_ID_W'(CHANNEL_ID);

  slot_state_e           state_reg  [ROB_DEPTH];
  slot_state_e           state_next [ROB_DEPTH];
  logic [DATA_W-1:0]     data_reg   [ROB_DEPTH];
  logic [ROB_W-1:0]      head_reg, head_next;
  logic [ROB_W-1:0]      tail_reg, tail_next;
  logic [ROB_W:0]        count_reg, count_next;
  logic                  err_reg, err_next;

  logic [ROB_W-1:0]      bank_tag  [NUM_BANKS];
  logic [DATA_W-1:0]     bank_data [NUM_BANKS];
  logic [NUM_BANKS-1:0]  match;
  logic [NUM_BANKS-1:0]  accept;
  logic [NUM_BANKS-1:0]  write_en;
  logic                  alloc_fire;
  logic                  out_fire;

  // Per-bank decode. A bank is accepted when it targets this channel and no
  // lower-index matching bank claims the same tag this cycle, so at most one
  // accepted bank ever addresses a given slot.
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic dup_hit;

    assign bank_tag[gi]  = bank_rob_num_i[gi*ROB_W +: ROB_W];
    assign bank_data[gi] = bank_data_i[gi*DATA_W +: DATA_W];
    assign match[gi]     = bank_valid_i[gi] &
                           (bank_ch_id_i[gi*CH_ID_W +: CH_ID_W] == CH_C);

    always_comb begin
      dup_hit = 1'b0;
      for (int a = 0; a < gi; a++) begin
        if (match[a] && (bank_tag[a] == bank_tag[gi])) begin
          dup_hit = 1'b1;
        end
      end
    end

    assign accept[gi]   = match[gi] & ~dup_hit;
    // Only a slot that is waiting for its response may be written; this
    // looks at registered state, so a slot allocated this very cycle still
    // reads FREE and the write is rejected.
    assign write_en[gi] = accept[gi] & (state_reg[bank_tag[gi]] == SLOT_ALLOC);
  end

  assign bank_allowIn_o = accept;

  // Handshakes
  assign alloc_ready_o   = (count_reg < DEPTH_C);
  assign alloc_fire      = alloc_valid_i & alloc_ready_o;
  assign alloc_rob_num_o = tail_reg;

  assign out_valid_o     = (state_reg[head_reg] == SLOT_DONE);
  assign out_fire        = out_valid_o & out_ready_i;
  assign out_rob_num_o   = head_reg;
  assign out_data_o      = data_reg[head_reg];

  assign count_o         = count_reg;
  assign err_o           = err_reg;

  // Next-state. Alloc (tail, FREE), write (ALLOC slots) and retire (head,
  // DONE) always address distinct slots, so applying them in sequence is
  // order-independent.
  always_comb begin
    for (int s = 0; s < ROB_DEPTH; s++) begin
      state_next[s] = state_reg[s];
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (write_en[b]) begin
        state_next[bank_tag[b]] = SLOT_DONE;
      end
    end
    if (alloc_fire) begin
      state_next[tail_reg] = SLOT_ALLOC;
    end
    if (out_fire) begin
      state_next[head_reg] = SLOT_FREE;
    end
  end

  always_comb begin
    head_next  = out_fire   ? head_reg + ROB_W'(1) : head_reg;
    tail_next  = alloc_fire ? tail_reg + ROB_W'(1) : tail_reg;
    count_next = count_reg;
    case ({alloc_fire, out_fire})
      2'b10:   count_next = count_reg + (ROB_W + 1)'(1);
      2'b01:   count_next = count_reg - (ROB_W + 1)'(1);
      default: count_next = count_reg;
    endcase
    // Sticky error: a same-tag collision between matching banks, or an
    // accepted write that found its slot FREE or already DONE.
    err_next = err_reg | (|(match & ~accept)) | (|(accept & ~write_en));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int s = 0; s < ROB_DEPTH; s++) begin
        state_reg[s] <= SLOT_FREE;
      end
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      for (int s = 0; s < ROB_DEPTH; s++) begin
        state_reg[s] <= state_next[s];
      end
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  // Slot payload is not reset; a slot is only read once its state is DONE.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (write_en[b]) begin
        data_reg[bank_tag[b]] <= bank_data[b];
      end
    end
  end

endmodule

// File: tb/tb_xbar_rob_channel.sv
// tb_xbar_rob_channel
//   Scenario tasks drive the reorder buffer; expected {tag, data} pairs are
//   queued at allocation and compared as the head retires.
module tb_xbar_rob_channel;

  localparam int NB    = 4;
  localparam int DEPTH = 8;
  localparam int RW    = 3;
  localparam int DW    = 128;
  localparam int CW    = 2;
  localparam int CH    = 0;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic [NB-1:0]     bank_valid_i;
  logic [NB-1:0]     bank_allowIn_o;
  logic [NB*CW-1:0]  bank_ch_id_i;
  logic [NB*RW-1:0]  bank_rob_num_i;
  logic [NB*DW-1:0]  bank_data_i;
  logic              alloc_valid_i;
  logic              alloc_ready_o;
  logic [RW-1:0]     alloc_rob_num_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [RW-1:0]     out_rob_num_o;
  logic [DW-1:0]     out_data_o;
  logic [RW:0]       count_o;
  logic              err_o;

  typedef struct packed {
    logic [RW-1:0] tag;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  xbar_rob_channel #(
    .CHANNEL_ID (CH),
    .NUM_BANKS  (NB),
    .ROB_DEPTH  (DEPTH),
    .DATA_W     (DW),
    .CH_ID_W    (CW)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .bank_valid_i    (bank_valid_i),
    .bank_allowIn_o  (bank_allowIn_o),
    .bank_ch_id_i    (bank_ch_id_i),
    .bank_rob_num_i  (bank_rob_num_i),
    .bank_data_i     (bank_data_i),
    .alloc_valid_i   (alloc_valid_i),
    .alloc_ready_o   (alloc_ready_o),
    .alloc_rob_num_o (alloc_rob_num_o),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_rob_num_o   (out_rob_num_o),
    .out_data_o      (out_data_o),
    .count_o         (count_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] mk(input int r, input int t);
    return {32'(r), 32'(t), 32'hA5A5_0000 + 32'(r * 16 + t), 32'h0000_00A0 + 32'(t)};
  endfunction

  task automatic push_exp(input int tag, input logic [DW-1:0] data);
    exp_t e;
    e.tag  = RW'(tag);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic clear_banks();
    bank_valid_i   = '0;
    bank_rob_num_i = '0;
    bank_data_i    = '0;
    for (int b = 0; b < NB; b++) bank_ch_id_i[b*CW +: CW] = CW'(CH);
  endtask

  task automatic set_bank(input int b, input int tag, input logic [DW-1:0] data, input int ch);
    bank_valid_i[b]           = 1'b1;
    bank_rob_num_i[b*RW +: RW] = RW'(tag);
    bank_data_i[b*DW +: DW]   = data;
    bank_ch_id_i[b*CW +: CW]  = CW'(ch);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    clear_banks();
    alloc_valid_i = 1'b0;
    out_ready_i   = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    exp_q.delete();
  endtask

  // Retire check used at negedge+1 of each cycle a head is expected.
  task automatic expect_head(input string name, input int j);
    exp_t e;
    checks++;
    if (out_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid[%0d] got %b expected 1", name, j, out_valid_o);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected[%0d] got tag %0d with empty scoreboard", name, j, out_rob_num_o);
    end else begin
      e = exp_q.pop_front();
      if (out_rob_num_o !== e.tag || out_data_o !== e.data) begin
        errors++;
        $display("FAIL %s_head[%0d] got tag %0d data %h expected tag %0d data %h",
                 name, j, out_rob_num_o, out_data_o, e.tag, e.data);
      end else begin
        $display("retire %s tag %0d data %h", name, out_rob_num_o, out_data_o);
      end
    end
  endtask

  task automatic test_reset();
    clear_banks();
    alloc_valid_i = 1'b0;
    out_ready_i   = 1'b0;
    rst_i         = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checks++;
    if (alloc_ready_o !== 1'b1 || out_valid_o !== 1'b0 || count_o !== 4'd0 ||
        err_o !== 1'b0 || bank_allowIn_o !== 4'b0000 || alloc_rob_num_o !== 3'd0) begin
      errors++;
      $display("FAIL reset got ready %b valid %b count %0d err %b allow %b tag %0d expected 1 0 0 0 0000 0",
               alloc_ready_o, out_valid_o, count_o, err_o, bank_allowIn_o, alloc_rob_num_o);
    end
  endtask

  task automatic test_out_of_order();
    int bk[4] = '{2, 0, 3, 1};
    int tg[4] = '{3, 1, 2, 0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      alloc_valid_i = 1'b1;
      #1;
      checks++;
      if (alloc_ready_o !== 1'b1 || alloc_rob_num_o !== RW'(i)) begin
        errors++;
        $display("FAIL ooo_alloc[%0d] got ready %b tag %0d expected 1 %0d", i, alloc_ready_o, alloc_rob_num_o, i);
      end
      push_exp(i, DW'(160 + i));
    end
    @(negedge clk_i);
    alloc_valid_i = 1'b0;
    out_ready_i   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      clear_banks();
      set_bank(bk[k], tg[k], DW'(160 + tg[k]), CH);
      #1;
      checks++;
      if (bank_allowIn_o !== NB'(1 << bk[k]) || out_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL ooo_write[%0d] got allow %b valid %b expected %b 0", k, bank_allowIn_o, out_valid_o, NB'(1 << bk[k]));
      end
    end
    @(negedge clk_i);
    clear_banks();
    #1;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) begin @(negedge clk_i); #1; end
      expect_head("ooo", j);
    end
    @(negedge clk_i);
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || count_o !== 4'd0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL ooo_end got valid %b count %0d err %b expected 0 0 0", out_valid_o, count_o, err_o);
    end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk_i);
      alloc_valid_i = 1'b1;
      #1;
      checks++;
      if (alloc_rob_num_o !== RW'(i)) begin
        errors++;
        $display("FAIL full_alloc[%0d] got tag %0d expected %0d", i, alloc_rob_num_o, i);
      end
      push_exp(i, mk(1, i));
    end
    @(negedge clk_i);
    alloc_valid_i = 1'b0;
    set_bank(0, 0, mk(1, 0), CH);
    #1;
    checks++;
    if (count_o !== 4'd8 || alloc_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_state got count %0d ready %b expected 8 0", count_o, alloc_ready_o);
    end
    @(negedge clk_i);
    clear_banks();
    alloc_valid_i = 1'b1;
    out_ready_i   = 1'b1;
    #1;
    checks++;
    if (alloc_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_refuse got ready %b expected 0", alloc_ready_o);
    end
    expect_head("full", 0);
    @(negedge clk_i);
    #1;
    checks++;
    if (count_o !== 4'd7 || alloc_ready_o !== 1'b1 || alloc_rob_num_o !== 3'd0) begin
      errors++;
      $display("FAIL full_wrap got count %0d ready %b tag %0d expected 7 1 0", count_o, alloc_ready_o, alloc_rob_num_o);
    end
    push_exp(0, mk(2, 0));
    @(negedge clk_i);
    alloc_valid_i = 1'b0;
    out_ready_i   = 1'b0;
    #1;
    checks++;
    if (count_o !== 4'd8) begin
      errors++;
      $display("FAIL full_refill got count %0d expected 8", count_o);
    end
    for (int t = 1; t <= DEPTH; t++) begin
      @(negedge clk_i);
      clear_banks();
      set_bank(t % NB, t % DEPTH, (t == DEPTH) ? mk(2, 0) : mk(1, t), CH);
    end
    @(negedge clk_i);
    clear_banks();
    out_ready_i = 1'b1;
    #1;
    for (int j = 1; j <= DEPTH; j++) begin
      if (j > 1) begin @(negedge clk_i); #1; end
      expect_head("full", j);
    end
    @(negedge clk_i);
    out_ready_i = 1'b0;
    #1;
    checks++;
    if (count_o !== 4'd0 || out_valid_o !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL full_end got count %0d valid %b err %b expected 0 0 0", count_o, out_valid_o, err_o);
    end
  endtask

  // Continues from test_full_wrap: nine tags issued and retired, so head = tail = 1.
  task automatic test_backpressure();
    exp_t e;
    @(negedge clk_i);
    out_ready_i   = 1'b0;
    alloc_valid_i = 1'b1;
    #1;
    checks++;
    if (alloc_rob_num_o !== 3'd1) begin
      errors++;
      $display("FAIL bp_alloc got tag %0d expected 1", alloc_rob_num_o);
    end
    push_exp(1, mk(3, 1));
    @(negedge clk_i);
    alloc_valid_i = 1'b0;
    set_bank(3, 1, mk(3, 1), CH);
    @(negedge clk_i);
    clear_banks();
    for (int k = 0; k < 5; k++) begin
      #1;
      e = exp_q[0];
      checks++;
      if (out_valid_o !== 1'b1 || out_rob_num_o !== e.tag || out_data_o !== e.data || count_o !== 4'd1) begin
        errors++;
        $display("FAIL bp_hold[%0d] got valid %b tag %0d data %h count %0d expected 1 %0d %h 1",
                 k, out_valid_o, out_rob_num_o, out_data_o, count_o, e.tag, e.data);
      end
      @(negedge clk_i);
    end
    out_ready_i = 1'b1;
    #1;
    expect_head("bp", 0);
    @(negedge clk_i);
    out_ready_i = 1'b0;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || count_o !== 4'd0) begin
      errors++;
      $display("FAIL bp_retire got valid %b count %0d expected 0 0", out_valid_o, count_o);
    end
  endtask

  task automatic test_parallel_conflict();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      alloc_valid_i = 1'b1;
      push_exp(i, mk(4, i));
    end
    @(negedge clk_i);
    alloc_valid_i = 1'b0;
    set_bank(0, 4, mk(4, 4), CH);
    set_bank(1, 5, mk(4, 5), CH);
    #1;
    checks++;
    if (bank_allowIn_o !== 4'b0011) begin
      errors++;
      $display("FAIL par_allow got %b expected 0011", bank_allowIn_o);
    end
    @(negedge clk_i);
    clear_banks();
    set_bank(1, 6, mk(4, 6), CH);
    set_bank(3, 6, mk(5, 6), CH);
    #1;
    checks++;
    if (bank_allowIn_o !== 4'b0010 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL conf_allow got allow %b err %b expected 0010 0", bank_allowIn_o, err_o);
    end
    @(negedge clk_i);
    clear_banks();
    for (int b = 0; b < NB; b++) set_bank(b, b, mk(4, b), CH);
    #1;
    checks++;
    if (err_o !== 1'b1 || bank_allowIn_o !== 4'b1111) begin
      errors++;
      $display("FAIL conf_err got err %b allow %b expected 1 1111", err_o, bank_allowIn_o);
    end
    @(negedge clk_i);
    clear_banks();
    out_ready_i = 1'b1;
    #1;
    for (int j = 0; j < 7; j++) begin
      if (j > 0) begin @(negedge clk_i); #1; end
      expect_head("par", j);
    end
    @(negedge clk_i);
    out_ready_i = 1'b0;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || count_o !== 4'd0 || err_o !== 1'b1) begin
      errors++;
      $display("FAIL par_end got valid %b count %0d err %b expected 0 0 1", out_valid_o, count_o, err_o);
    end
  endtask

  task automatic test_filter_illegal();
    do_reset();
    @(negedge clk_i);
    set_bank(0, 0, mk(6, 0), CH + 1);
    #1;
    checks++;
    if (bank_allowIn_o !== 4'b0000) begin
      errors++;
      $display("FAIL filt_allow got %b expected 0000", bank_allowIn_o);
    end
    @(negedge clk_i);
    clear_banks();
    #1;
    checks++;
    if (err_o !== 1'b0 || out_valid_o !== 1'b0 || count_o !== 4'd0) begin
      errors++;
      $display("FAIL filt_state got err %b valid %b count %0d expected 0 0 0", err_o, out_valid_o, count_o);
    end
    // Write to the FREE head slot: must flag and leave the slot FREE.
    set_bank(2, 0, mk(6, 9), CH);
    #1;
    checks++;
    if (bank_allowIn_o !== 4'b0100) begin
      errors++;
      $display("FAIL free_allow got %b expected 0100", bank_allowIn_o);
    end
    @(negedge clk_i);
    clear_banks();
    #1;
    checks++;
    if (err_o !== 1'b1 || out_valid_o !== 1'b0 || count_o !== 4'd0) begin
      errors++;
      $display("FAIL free_write got err %b valid %b count %0d expected 1 0 0", err_o, out_valid_o, count_o);
    end
    alloc_valid_i = 1'b1;
    push_exp(0, mk(6, 0));
    @(negedge clk_i);
    alloc_valid_i = 1'b0;
    set_bank(1, 0, mk(6, 0), CH);
    @(negedge clk_i);
    clear_banks();
    out_ready_i = 1'b1;
    #1;
    expect_head("free", 0);
    @(negedge clk_i);
    out_ready_i = 1'b0;
  endtask

  task automatic test_alloc_write_same();
    do_reset();
    @(negedge clk_i);
    alloc_valid_i = 1'b1;
    set_bank(0, 0, mk(7, 9), CH);
    push_exp(0, mk(7, 0));
    @(negedge clk_i);
    alloc_valid_i = 1'b0;
    clear_banks();
    #1;
    checks++;
    if (err_o !== 1'b1 || out_valid_o !== 1'b0 || count_o !== 4'd1) begin
      errors++;
      $display("FAIL same_slot got err %b valid %b count %0d expected 1 0 1", err_o, out_valid_o, count_o);
    end
    set_bank(2, 0, mk(7, 0), CH);
    @(negedge clk_i);
    clear_banks();
    out_ready_i = 1'b1;
    #1;
    expect_head("same", 0);
    @(negedge clk_i);
    out_ready_i = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk_i);
    alloc_valid_i = 1'b1;
    @(negedge clk_i);
    set_bank(0, 0, mk(8, 0), CH);
    @(negedge clk_i);
    alloc_valid_i = 1'b0;
    clear_banks();
    #1;
    checks++;
    if (count_o !== 4'd2 || out_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL async_pre got count %0d valid %b expected 2 1", count_o, out_valid_o);
    end
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if (count_o !== 4'd0 || out_valid_o !== 1'b0 || alloc_ready_o !== 1'b1 || alloc_rob_num_o !== 3'd0) begin
      errors++;
      $display("FAIL async_reset got count %0d valid %b ready %b tag %0d expected 0 0 1 0",
               count_o, out_valid_o, alloc_ready_o, alloc_rob_num_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_out_of_order();
    test_full_wrap();
    test_backpressure();
    test_parallel_conflict();
    test_filter_illegal();
    test_alloc_write_same();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
